seg7_scan: RTL and testbench

Seven-segment scan controller for the calculator display; it is the consumer of the divider's toggling `CLK_LED` refresh signal. It edge-detects that signal in the 100 MHz domain and advances a digit scan on each edge, inserting a blanking gap between digits to prevent ghosting. It double-buffers the displayed value so that updates land only on frame boundaries, and it performs hex decode, decimal-point drive and leading-zero suppression.

---
 rtl/seg7_scan.sv | 227 ++++++++++++++++++++++
 tb/tb_seg7_scan.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Seven-segment scan controller: edge-detected refresh ticks, blanking gap,
// frame-synchronous double-buffered value, hex decode and zero blanking.
module seg7_scan #(
  parameter int N_DIGITS     = 8,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    CLK_100MHz,
  input  logic                    RST,
  input  logic                    i_ce,
  input  logic                    i_led_clk,
  input  logic [4*N_DIGITS-1:0]   i_value,
  input  logic [N_DIGITS-1:0]     i_dp,
  input  logic                    i_lz_en,
  input  logic                    i_load,
  output logic [N_DIGITS-1:0]     o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_pending,
  output logic                    o_frame_done
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int VW = 4 * N_DIGITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  localparam logic [IW-1:0] I_LAST = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLANK_CYCLES - 1);

  logic            led_q;
  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [VW-1:0]   stg_val_q, stg_val_d;
  logic [N_DIGITS-1:0] stg_dp_q, stg_dp_d;
  logic            stg_lz_q, stg_lz_d;
  logic            pend_q, pend_d;
  logic [VW-1:0]   dsp_val_q, dsp_val_d;
  logic [N_DIGITS-1:0] dsp_dp_q, dsp_dp_d;
  logic [N_DIGITS-1:0] mask_q, mask_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            fd_q, fd_d;

  logic            tick;
  logic            wrap;
  logic            dsp_load;
  logic            lz_src;
  logic [3:0]      nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Walk from the top digit down; a digit blanks while everything above it is zero.
  function automatic logic [N_DIGITS-1:0] lz_mask(
    input logic [VW-1:0] v,
    input logic          en
  );
    logic [N_DIGITS-1:0] m;
    logic z;
    m = '0;
    z = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      z = z & (v[4*k +: 4] == 4'h0);
      m[k] = en & z;
    end
    return m;
  endfunction

  assign tick = i_ce & (i_led_clk ^ led_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    wrap    = 1'b0;
    if (i_ce) begin
      unique case (state_q)
        IDLE: begin
          if (tick) begin
            state_d = BLANK;
            idx_d   = '0;
            bcnt_d  = '0;
          end
        end
        BLANK: begin
          if (bcnt_q == B_LAST) begin
            state_d = SHOW;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (tick) begin
            state_d = BLANK;
            bcnt_d  = '0;
            if (idx_q == I_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stg_val_d = stg_val_q;
    stg_dp_d  = stg_dp_q;
    stg_lz_d  = stg_lz_q;
    pend_d    = pend_q;
    dsp_val_d = dsp_val_q;
    dsp_dp_d  = dsp_dp_q;
    mask_d    = mask_q;
    dsp_load  = 1'b0;
    lz_src    = 1'b0;
    if (wrap && i_load) begin
      dsp_val_d = i_value;
      dsp_dp_d  = i_dp;
      lz_src    = i_lz_en;
      dsp_load  = 1'b1;
      pend_d    = 1'b0;
    end else begin
      if (wrap && pend_q) begin
        dsp_val_d = stg_val_q;
        dsp_dp_d  = stg_dp_q;
        lz_src    = stg_lz_q;
        dsp_load  = 1'b1;
        pend_d    = 1'b0;
      end
      if (i_load) begin
        stg_val_d = i_value;
        stg_dp_d  = i_dp;
        stg_lz_d  = i_lz_en;
        pend_d    = 1'b1;
      end
    end
    if (dsp_load) begin
      mask_d = lz_mask(dsp_val_d, lz_src);
    end
  end

  // Outputs are decoded from next-state values so they register in step with the FSM.
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    fd_d  = wrap;
    nib   = dsp_val_d[{idx_d, 2'b00} +: 4];
    if (state_d == SHOW) begin
      an_d[idx_d] = 1'b0;
      seg_d       = mask_d[idx_d] ? 7'h7F : hex7(nib);
      dp_d        = ~dsp_dp_d[idx_d];
    end
  end

  always_ff @(posedge CLK_100MHz) begin
    if (RST) begin
      led_q     <= 1'b0;
      state_q   <= IDLE;
      idx_q     <= '0;
      bcnt_q    <= '0;
      stg_val_q <= '0;
      stg_dp_q  <= '0;
      stg_lz_q  <= 1'b0;
      pend_q    <= 1'b0;
      dsp_val_q <= '0;
      dsp_dp_q  <= '0;
      mask_q    <= '0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      led_q     <= i_led_clk;
      state_q   <= state_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      stg_val_q <= stg_val_d;
      stg_dp_q  <= stg_dp_d;
      stg_lz_q  <= stg_lz_d;
      pend_q    <= pend_d;
      dsp_val_q <= dsp_val_d;
      dsp_dp_q  <= dsp_dp_d;
      mask_q    <= mask_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      fd_q      <= fd_d;
    end
  end

  assign o_an         = an_q;
  assign o_seg        = seg_q;
  assign o_dp         = dp_q;
  assign o_pending    = pend_q;
  assign o_frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: directed scenarios plus random ticks, freezes, loads
// and resets, all compared every cycle against a behavioural display model.
module tb_seg7_scan;

  localparam int N = 8;
  localparam int B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, ce, led, load, lz;
  logic [4*N-1:0] val;
  logic [N-1:0]   dp;
  logic [N-1:0]   an;
  logic [6:0]     seg;
  logic           odp, pend, fd;

  seg7_scan #(.N_DIGITS(N), .BLANK_CYCLES(B)) dut (
    .CLK_100MHz  (clk),
    .RST         (rst),
    .i_ce        (ce),
    .i_led_clk   (led),
    .i_value     (val),
    .i_dp        (dp),
    .i_lz_en     (lz),
    .i_load      (load),
    .o_an        (an),
    .o_seg       (seg),
    .o_dp        (odp),
    .o_pending   (pend),
    .o_frame_done(fd)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] hex_tab [16];
  logic [6:0] scan_exp [8];

  // model: which digit is lit (-1 = none yet) and how many gap cycles remain
  logic           m_led;
  int             m_dig;
  int             m_gap;
  logic [4*N-1:0] s_val, d_val;
  logic [N-1:0]   s_dp, d_dp;
  logic           s_lz, d_lz, m_pend, m_fd;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic tk, wrap;
    tk   = ce && (led != m_led);
    wrap = 1'b0;
    if (rst) begin
      m_led = 1'b0; m_dig = -1; m_gap = 0;
      s_val = '0; s_dp = '0; s_lz = 1'b0;
      d_val = '0; d_dp = '0; d_lz = 1'b0;
      m_pend = 1'b0; m_fd = 1'b0;
    end else begin
      m_led = led;
      if (ce) begin
        if (m_dig < 0) begin
          if (tk) begin m_dig = 0; m_gap = B; end
        end else if (m_gap > 0) begin
          m_gap--;
        end else if (tk) begin
          wrap  = (m_dig == N - 1);
          m_dig = (m_dig + 1) % N;
          m_gap = B;
        end
      end
      if (wrap && load) begin
        d_val = val; d_dp = dp; d_lz = lz; m_pend = 1'b0;
      end else begin
        if (wrap && m_pend) begin
          d_val = s_val; d_dp = s_dp; d_lz = s_lz; m_pend = 1'b0;
        end
        if (load) begin
          s_val = val; s_dp = dp; s_lz = lz; m_pend = 1'b1;
        end
      end
      m_fd = wrap;
    end
  endtask

  function automatic logic lit();
    return (m_dig >= 0) && (m_gap == 0);
  endfunction

  function automatic logic [N-1:0] exp_an();
    logic [N-1:0] one;
    one = 1;
    if (!lit()) return '1;
    return ~(one << m_dig);
  endfunction

  function automatic logic [6:0] exp_seg();
    logic [4*N-1:0] upper;
    if (!lit()) return 7'h7F;
    upper = d_val >> (4 * m_dig);
    if (d_lz && m_dig != 0 && upper == 0) return 7'h7F;
    return hex_tab[d_val[4*m_dig +: 4]];
  endfunction

  function automatic logic exp_dp();
    if (!lit()) return 1'b1;
    return ~d_dp[m_dig];
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("an",   an,   exp_an());
    chk("seg",  seg,  exp_seg());
    chk("dp",   odp,  exp_dp());
    chk("pend", pend, m_pend);
    chk("fd",   fd,   m_fd);
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic toggle();
    led = ~led;
    cyc();
  endtask

  task automatic load_val(logic [4*N-1:0] v, logic [N-1:0] p, logic z);
    val = v; dp = p; lz = z; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  logic [N-1:0] a_exp;

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    scan_exp = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h30, 7'h24, 7'h79, 7'h40};
    m_led = 1'b0; m_dig = -1; m_gap = 0;
    s_val = '0; s_dp = '0; s_lz = 1'b0;
    d_val = '0; d_dp = '0; d_lz = 1'b0;
    m_pend = 1'b0; m_fd = 1'b0;
    rst = 1'b1; ce = 1'b1; led = 1'b0; load = 1'b0;
    lz = 1'b0; val = '0; dp = '0;
    @(negedge clk);
    run(3);
    rst = 1'b0;
    cyc();
    chk("rst_an",   an,   8'hFF);
    chk("rst_seg",  seg,  7'h7F);
    chk("rst_dp",   odp,  1'b1);
    chk("rst_pend", pend, 1'b0);
    chk("rst_fd",   fd,   1'b0);

    toggle();
    chk("gap1", an, 8'hFF);
    repeat (3) begin
      cyc();
      chk("gap", an, 8'hFF);
    end
    cyc();
    chk("first_an",  an,  8'hFE);
    chk("first_seg", seg, 7'h40);

    load_val(32'h0123ABCD, '0, 1'b0);
    chk("pend_set", pend, 1'b1);
    repeat (7) begin toggle(); run(19); end
    for (int d = 0; d < N; d++) begin
      toggle();
      if (d == 0) begin
        chk("scan_fd",   fd,   1'b1);
        chk("scan_pend", pend, 1'b0);
      end
      run(4);
      a_exp = ~(N'(1) << d);
      chk("scan_an",  an,  a_exp);
      chk("scan_seg", seg, scan_exp[d]);
      run(15);
    end
    toggle();
    run(4);
    chk("scan_back", an, 8'hFE);

    toggle(); run(4);
    load_val(32'h11111111, '0, 1'b0);
    chk("fb_pend", pend, 1'b1);
    chk("fb_old1", seg,  7'h46);
    toggle(); run(4);
    chk("fb_old2", seg, 7'h03);
    repeat (5) begin toggle(); run(6); end
    toggle(); run(4);
    chk("fb_new",   seg,  7'h79);
    chk("fb_clear", pend, 1'b0);

    repeat (7) begin toggle(); run(6); end
    val = 32'h00000005; load = 1'b1; led = ~led;
    cyc();
    load = 1'b0;
    chk("byp_pend", pend, 1'b0);
    chk("byp_fd",   fd,   1'b1);
    run(4);
    chk("byp_an",  an,  8'hFE);
    chk("byp_seg", seg, 7'h12);

    load_val(32'h00000050, 8'h04, 1'b1);
    lz = 1'b0; dp = '0;
    repeat (7) begin toggle(); run(6); end
    for (int d = 0; d < N; d++) begin
      toggle(); run(4);
      chk("lz_seg", seg, (d == 0) ? 7'h40 : (d == 1) ? 7'h12 : 7'h7F);
      chk("lz_dp",  odp, (d == 2) ? 1'b0 : 1'b1);
    end
    load_val('0, '0, 1'b1);
    for (int d = 0; d < N; d++) begin
      toggle(); run(4);
      chk("zero_seg", seg, (d == 0) ? 7'h40 : 7'h7F);
    end

    toggle();
    cyc();
    ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) led = ~led;
      cyc();
      chk("frz_an", an, 8'hFF);
    end
    ce = 1'b1;
    run(2);
    chk("frz_gap", an, 8'hFF);
    cyc();
    chk("frz_show", an, 8'hFE);

    toggle(); run(4);
    chk("mid_an", an, 8'hFD);
    rst = 1'b1; led = 1'b0;
    cyc();
    chk("mid_rst_an",  an,  8'hFF);
    chk("mid_rst_seg", seg, 7'h7F);
    rst = 1'b0;
    cyc();
    toggle(); run(4);
    chk("mid_restart", an, 8'hFE);

    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 299) == 0);
      ce   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) led = ~led;
      load = ($urandom_range(0, 39) == 0);
      if (load) begin
        for (int k = 0; k < N; k++)
          val[4*k +: 4] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
        dp = N'($urandom);
        lz = 1'($urandom_range(0, 1));
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
